emulador_teclado: RTL

- Behavioural-synthesisable model of a 4x4 matrix keypad: the physical end of the keypad scanning interface.
- Takes a key code through a valid/ready handshake and "presses" that key for a programmable time.
- While the key is pressed, it answers the scanner's column drive by pulling the matching row low; contact bounce is added at press and at release.
- Used in loopback tests and on-board self-test of the keypad interface, with no real keypad attached.

---
 rtl/emulador_teclado.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/emulador_teclado.sv
// emulador_teclado: stands in for a 4x4 matrix keypad. A key taken over a
// valid/ready handshake is held closed for a programmable time. Contact
// bounce is applied at press and at release. While the contact is closed,
// the key's row line is pulled low whenever the scanner drives its column.
// Optional macro KEYPAD_MULTITECLA_EN adds a second key that closes at the
// same time as the first and uses the same timing.
//
// state       | meaning
// REPOSO      | contact open, ready to accept a key
// REB_PRESION | press bounce: starts closed, toggles every T_CONMUT cycles
// PULSADO     | contact solidly closed for T_PULSACION cycles
// REB_SUELTA  | release bounce: starts open, toggles every T_CONMUT cycles
// PAUSA       | forced idle for T_PAUSA cycles, hecho_o on the last cycle
module emulador_teclado #(
  parameter int T_PULSACION = 100000,
  parameter int T_REBOTE    = 200,
  parameter int T_CONMUT    = 8,
  parameter int T_PAUSA     = 100000
) (
  input  logic       clck_i,
  input  logic       locked,
  input  logic [1:0] columna_i,
  input  logic [3:0] tecla_i,
  input  logic       tecla_valid_i,
`ifdef KEYPAD_MULTITECLA_EN
  input  logic [3:0] tecla2_i,
  input  logic       tecla2_en_i,
`endif
  output logic       tecla_ready_o,
  output logic [3:0] filas_o,
  output logic [1:0] filas_codificadas_o,
  output logic       ocupado_o,
  output logic       hecho_o
);

  localparam int MAX_AB = (T_PULSACION > T_REBOTE) ? T_PULSACION : T_REBOTE;
  localparam int MAX_CD = (T_CONMUT > T_PAUSA) ? T_CONMUT : T_PAUSA;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int W      = $clog2(MAX_P + 1);

  // Down-counters load (length - 1) and finish when they reach zero.
  localparam logic [W-1:0] CARGA_REB  = W'((T_REBOTE > 0) ? T_REBOTE - 1 : 0);
  localparam logic [W-1:0] CARGA_PUL  = W'(T_PULSACION - 1);
  localparam logic [W-1:0] CARGA_PAU  = W'(T_PAUSA - 1);
  localparam logic [W-1:0] CARGA_CONM = W'(T_CONMUT - 1);

  typedef enum logic [2:0] {
    REPOSO      = 3'd0,
    REB_PRESION = 3'd1,
    PULSADO     = 3'd2,
    REB_SUELTA  = 3'd3,
    PAUSA       = 3'd4
  } estado_t;

  estado_t      estado, estado_sig;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_conm;
  logic         fase;
  logic         contacto;
  logic         acepta;
  logic [1:0]   fila_k, col_k;
  logic [3:0]   filas_sig;
  logic [1:0]   cod_sig;

`ifdef KEYPAD_MULTITECLA_EN
  logic [1:0]   fila2_k, col2_k;
  logic         en2_k;
`endif

  // Key map: returns {row, col} for a key value.
  function automatic logic [3:0] mapa(input logic [3:0] t);
    logic [3:0] rc;
    case (t)
      4'h1: rc = {2'd0, 2'd0};
      4'h2: rc = {2'd0, 2'd1};
      4'h3: rc = {2'd0, 2'd2};
      4'hA: rc = {2'd0, 2'd3};
      4'h4: rc = {2'd1, 2'd0};
      4'h5: rc = {2'd1, 2'd1};
      4'h6: rc = {2'd1, 2'd2};
      4'hB: rc = {2'd1, 2'd3};
      4'h7: rc = {2'd2, 2'd0};
      4'h8: rc = {2'd2, 2'd1};
      4'h9: rc = {2'd2, 2'd2};
      4'hC: rc = {2'd2, 2'd3};
      4'hE: rc = {2'd3, 2'd0};
      4'h0: rc = {2'd3, 2'd1};
      4'hF: rc = {2'd3, 2'd2};
      default: rc = {2'd3, 2'd3};  // 4'hD
    endcase
    return rc;
  endfunction

  assign acepta = tecla_valid_i & tecla_ready_o;

  // State register with synchronous reset.
  always_ff @(posedge clck_i) begin
    if (!locked) estado <= REPOSO;
    else         estado <= estado_sig;
  end

  // Next-state logic: each timed phase ends when its counter reaches zero.
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:      if (acepta) estado_sig = (T_REBOTE > 0) ? REB_PRESION : PULSADO;
      REB_PRESION: if (cnt == '0) estado_sig = PULSADO;
      PULSADO:     if (cnt == '0) estado_sig = (T_REBOTE > 0) ? REB_SUELTA : PAUSA;
      REB_SUELTA:  if (cnt == '0) estado_sig = PAUSA;
      PAUSA:       if (cnt == '0) estado_sig = REPOSO;
      default:     estado_sig = REPOSO;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    tecla_ready_o = (estado == REPOSO) & locked;
    ocupado_o     = (estado != REPOSO);
    hecho_o       = (estado == PAUSA) && (cnt == '0);
    contacto      = 1'b0;
    case (estado)
      REB_PRESION: contacto = ~fase;
      PULSADO:     contacto = 1'b1;
      REB_SUELTA:  contacto = fase;
      default:     contacto = 1'b0;
    endcase
  end

  // Phase counter: reload on every state change, otherwise count down to zero.
  always_ff @(posedge clck_i) begin
    if (!locked) begin
      cnt <= '0;
    end else if (estado_sig != estado) begin
      case (estado_sig)
        REB_PRESION, REB_SUELTA: cnt <= CARGA_REB;
        PULSADO:                 cnt <= CARGA_PUL;
        PAUSA:                   cnt <= CARGA_PAU;
        default:                 cnt <= '0;
      endcase
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Bounce toggle timer: fase flips every T_CONMUT cycles inside a bounce phase.
  always_ff @(posedge clck_i) begin
    if (!locked) begin
      cnt_conm <= '0;
      fase     <= 1'b0;
    end else if (estado_sig != estado) begin
      cnt_conm <= CARGA_CONM;
      fase     <= 1'b0;
    end else if (estado == REB_PRESION || estado == REB_SUELTA) begin
      if (cnt_conm == '0) begin
        cnt_conm <= CARGA_CONM;
        fase     <= ~fase;
      end else begin
        cnt_conm <= cnt_conm - 1'b1;
      end
    end
  end

  // Latch the accepted key as (row, col).
  always_ff @(posedge clck_i) begin
    if (!locked) begin
      fila_k <= 2'd0;
      col_k  <= 2'd0;
`ifdef KEYPAD_MULTITECLA_EN
      fila2_k <= 2'd0;
      col2_k  <= 2'd0;
      en2_k   <= 1'b0;
`endif
    end else if (acepta) begin
      {fila_k, col_k} <= mapa(tecla_i);
`ifdef KEYPAD_MULTITECLA_EN
      {fila2_k, col2_k} <= mapa(tecla2_i);
      en2_k             <= tecla2_en_i;
`endif
    end
  end

  // Row lines seen by the scanner; the lowest-numbered active row wins the encoding.
  always_comb begin
    filas_sig = 4'hF;
    if (contacto && (columna_i == col_k)) filas_sig[~fila_k] = 1'b0;
`ifdef KEYPAD_MULTITECLA_EN
    if (contacto && en2_k && (columna_i == col2_k)) filas_sig[~fila2_k] = 1'b0;
`endif
    if      (!filas_sig[3]) cod_sig = 2'b11;
    else if (!filas_sig[2]) cod_sig = 2'b10;
    else if (!filas_sig[1]) cod_sig = 2'b01;
    else                    cod_sig = 2'b00;
  end

  // Registered row outputs: one cycle of latency from column or contact changes.
  always_ff @(posedge clck_i) begin
    if (!locked) begin
      filas_o             <= 4'hF;
      filas_codificadas_o <= 2'b00;
    end else begin
      filas_o             <= filas_sig;
      filas_codificadas_o <= cod_sig;
    end
  end

endmodule
